graph_line_scheduler: RTL

Line-level scheduler and ping-pong line buffer for the OSD graphic generator. It sequences the instruction engine one video line at a time and owns the two line buffers that the string, box and chart units write into. It streams completed lines out as AXI4-Stream video and clears each buffer as it reads it, so every line starts from the background colour. Render of line N+1 overlaps output of line N; stalls and underruns are handled explicitly.

---
 rtl/graph_line_scheduler.sv | 267 ++++++++++++++++++++++++++
 1 files changed

// File: rtl/graph_line_scheduler.sv
// ---------------------------------------------------------------------------
// graph_line_scheduler
//
// Line-level scheduler and ping-pong line buffer for the OSD graphic
// generator. One buffer is rendered by the instruction engine while the other
// is streamed out as AXI4-Stream video. Every pixel read also writes the
// background colour back, so each buffer is blank again once it is drained.
//
// Ports
//   hclk, hresetn        clock, asynchronous active-low reset
//   en                   gates the issue of new renders only
//   render_start         one-cycle pulse: engine begins line render_y
//   render_y[11:0]       line currently being rendered
//   render_done          engine finished the current line (R_BUSY only)
//   wr_en/wr_x/wr_d      pixel write from the execution units
//   tdata_m/tvalid_m/tready_m/tlast_m/tuser_m   video stream out
//   init_done            both buffers hold BG_COLOR
//   underrun_cnt[15:0]   saturating count of output stall episodes
// ---------------------------------------------------------------------------
module graph_line_scheduler #(
  parameter int          ACTIVE_HORI = 1024,
  parameter int          ACTIVE_VERT = 768,
  parameter logic [15:0] BG_COLOR    = 16'h0000
) (
  input  logic        hclk,
  input  logic        hresetn,
  input  logic        en,
  output logic        render_start,
  output logic [11:0] render_y,
  input  logic        render_done,
  input  logic        wr_en,
  input  logic [11:0] wr_x,
  input  logic [15:0] wr_d,
  output logic [15:0] tdata_m,
  output logic        tvalid_m,
  input  logic        tready_m,
  output logic        tlast_m,
  output logic        tuser_m,
  output logic        init_done,
  output logic [15:0] underrun_cnt
);

  localparam int          AW       = (ACTIVE_HORI > 1) ? $clog2(ACTIVE_HORI) : 1;
  localparam logic [12:0] HORI13   = 13'(ACTIVE_HORI);
  localparam logic [AW-1:0] LAST_COL = AW'(ACTIVE_HORI - 1);
  localparam logic [11:0] LAST_ROW = 12'(ACTIVE_VERT - 1);

  typedef enum logic [1:0] {R_IDLE, R_START, R_BUSY} r_state_t;
  typedef enum logic       {O_IDLE, O_STREAM}        o_state_t;

  // ---------------------------------------------------------------------
  // Init sweep: one address per cycle into both buffers at once.
  // ---------------------------------------------------------------------
  logic [AW-1:0] init_addr_reg;
  logic          init_done_reg;

  always_ff @(posedge hclk or negedge hresetn) begin
    if (!hresetn) begin
      init_addr_reg <= '0;
      init_done_reg <= 1'b0;
    end else if (!init_done_reg) begin
      init_addr_reg <= init_addr_reg + AW'(1);
      if (init_addr_reg == LAST_COL) init_done_reg <= 1'b1;
    end
  end

  // ---------------------------------------------------------------------
  // Buffer flags
  // ---------------------------------------------------------------------
  logic [1:0] buf_full_reg;
  logic [1:0] buf_first_reg;
  logic [1:0] buf_set;   // render side marks a buffer full
  logic [1:0] buf_clr;   // output side releases a buffer

  // ---------------------------------------------------------------------
  // Render FSM
  // ---------------------------------------------------------------------
  r_state_t    r_state_reg, r_state_next;
  logic [11:0] render_y_reg, render_y_next;
  logic        wsel_reg, wsel_next;

  always_comb begin
    r_state_next  = r_state_reg;
    render_y_next = render_y_reg;
    wsel_next     = wsel_reg;
    buf_set       = '0;
    unique case (r_state_reg)
      R_IDLE: begin
        if (init_done_reg && en && !buf_full_reg[wsel_reg]) r_state_next = R_START;
      end
      R_START: r_state_next = R_BUSY;
      R_BUSY: begin
        if (render_done) begin
          buf_set[wsel_reg] = 1'b1;
          wsel_next         = ~wsel_reg;
          render_y_next     = (render_y_reg == LAST_ROW) ? 12'd0 : render_y_reg + 12'd1;
          r_state_next      = R_IDLE;
        end
      end
      default: r_state_next = R_IDLE;
    endcase
  end

  always_ff @(posedge hclk or negedge hresetn) begin
    if (!hresetn) begin
      r_state_reg  <= R_IDLE;
      render_y_reg <= 12'd0;
      wsel_reg     <= 1'b0;
    end else begin
      r_state_reg  <= r_state_next;
      render_y_reg <= render_y_next;
      wsel_reg     <= wsel_next;
    end
  end

  // ---------------------------------------------------------------------
  // Output FSM and read pipeline
  //   stage 1: RAM read register (per buffer) + p1 tags
  //   stage 2: output register driving the stream
  // Reads are destructive (clear-on-read), so a read is only issued when
  // stage 1 is guaranteed to hand its word on, never overwriting it.
  // ---------------------------------------------------------------------
  o_state_t        o_state_reg, o_state_next;
  logic [12:0]     rd_col_reg, rd_col_next;   // next column to read
  logic            rsel_reg, rsel_next;
  logic            rsel_n;
  logic            rd_issue;
  logic [AW-1:0]   rd_addr;
  logic            rd_last, rd_first;
  logic            out_free, beat_last;
  logic            p1_vld_reg, p1_last_reg, p1_first_reg;
  logic            tvalid_reg, tlast_reg, tuser_reg;
  logic [15:0]     tdata_reg;
  logic [15:0]     underrun_reg;
  logic [1:0][15:0] ram_q;

  assign rsel_n    = ~rsel_reg;
  assign out_free  = !tvalid_reg || tready_m;
  assign beat_last = tvalid_reg && tready_m && tlast_reg;
  assign rd_addr   = rd_col_reg[AW-1:0];
  assign rd_last   = (rd_col_reg == HORI13 - 13'd1);
  assign rd_first  = (rd_col_reg == 13'd0) && buf_first_reg[rsel_reg];

  always_comb begin
    o_state_next = o_state_reg;
    rd_col_next  = rd_col_reg;
    rsel_next    = rsel_reg;
    rd_issue     = 1'b0;
    buf_clr      = '0;
    unique case (o_state_reg)
      O_IDLE: begin
        // Pipeline is empty in idle, so column 0 can be read straight away.
        if (init_done_reg && buf_full_reg[rsel_reg]) begin
          rd_issue     = 1'b1;
          rd_col_next  = 13'd1;
          o_state_next = O_STREAM;
        end
      end
      O_STREAM: begin
        if ((rd_col_reg < HORI13) && (!p1_vld_reg || out_free)) begin
          rd_issue    = 1'b1;
          rd_col_next = rd_col_reg + 13'd1;
        end
        if (beat_last) begin
          buf_clr[rsel_reg] = 1'b1;
          rsel_next         = rsel_n;
          rd_col_next       = 13'd0;
          o_state_next      = O_IDLE;
        end
      end
      default: o_state_next = O_IDLE;
    endcase
  end

  always_ff @(posedge hclk or negedge hresetn) begin
    if (!hresetn) begin
      o_state_reg   <= O_IDLE;
      rd_col_reg    <= 13'd0;
      rsel_reg      <= 1'b0;
      p1_vld_reg    <= 1'b0;
      p1_last_reg   <= 1'b0;
      p1_first_reg  <= 1'b0;
      tvalid_reg    <= 1'b0;
      tdata_reg     <= 16'd0;
      tlast_reg     <= 1'b0;
      tuser_reg     <= 1'b0;
      underrun_reg  <= 16'd0;
      buf_full_reg  <= '0;
      buf_first_reg <= '0;
    end else begin
      o_state_reg <= o_state_next;
      rd_col_reg  <= rd_col_next;
      rsel_reg    <= rsel_next;

      if (rd_issue) begin
        p1_vld_reg   <= 1'b1;
        p1_last_reg  <= rd_last;
        p1_first_reg <= rd_first;
      end else if (out_free) begin
        p1_vld_reg <= 1'b0;
      end

      if (out_free) begin
        tvalid_reg <= p1_vld_reg;
        if (p1_vld_reg) begin
          tdata_reg <= ram_q[rsel_reg];
          tlast_reg <= p1_last_reg;
          tuser_reg <= p1_first_reg;
        end
      end

      // A render finishing into the next buffer in this very cycle counts
      // as on time: the line is there when the output looks for it.
      if (beat_last && !(buf_full_reg[rsel_n] || buf_set[rsel_n]) &&
          (underrun_reg != 16'hFFFF))
        underrun_reg <= underrun_reg + 16'd1;

      // Set and clear always target different buffers, so both apply.
      buf_full_reg <= (buf_full_reg & ~buf_clr) | buf_set;
      for (int i = 0; i < 2; i++)
        if (buf_set[i]) buf_first_reg[i] <= (render_y_reg == 12'd0);
    end
  end

  // ---------------------------------------------------------------------
  // Line buffers. Port A: render write. Port B: init write, or read-first
  // read plus background clear at the same address.
  // The render and output sides never touch the same buffer at once
  // (render needs !full, output needs full).
  // ---------------------------------------------------------------------
  genvar gi;
  generate
    for (gi = 0; gi < 2; gi++) begin : g_buf
      logic [15:0]   mem [ACTIVE_HORI];
      logic [15:0]   q_reg;
      logic          a_we, b_rd, b_we;
      logic [AW-1:0] b_addr;

      assign a_we   = (r_state_reg == R_BUSY) && wr_en &&
                      ({1'b0, wr_x} < HORI13) && (wsel_reg == 1'(gi));
      assign b_rd   = rd_issue && (rsel_reg == 1'(gi));
      assign b_we   = !init_done_reg || b_rd;
      assign b_addr = init_done_reg ? rd_addr : init_addr_reg;

      always_ff @(posedge hclk) begin
        if (a_we) mem[wr_x[AW-1:0]] <= wr_d;
        if (b_rd) q_reg <= mem[b_addr];
        if (b_we) mem[b_addr] <= BG_COLOR;
      end

      assign ram_q[gi] = q_reg;
    end
  endgenerate

  // ---------------------------------------------------------------------
  // Outputs
  // ---------------------------------------------------------------------
  assign render_start = (r_state_reg == R_START);
  assign render_y     = render_y_reg;
  assign tdata_m      = tdata_reg;
  assign tvalid_m     = tvalid_reg;
  assign tlast_m      = tlast_reg;
  assign tuser_m      = tuser_reg;
  assign init_done    = init_done_reg;
  assign underrun_cnt = underrun_reg;

endmodule
